dsp_adc_framer: RTL and testbench

Single-clock frame assembler downstream of the ADC receiver. Consumes the receiver's {SoF, OF, sample} word stream and rebuilds fixed-length frames of interleaved multi-channel samples. Frames are buffered until complete; any frame with an overflow, truncation or buffer exhaustion is discarded whole. Only clean frames are emitted on a ready/valid stream with channel tag and last flag.

---
 rtl/dsp_adc_pkg.sv | 25 ++
 rtl/dsp_adc_frame_ram.sv | 36 +++
 rtl/dsp_adc_framer.sv | 183 ++++++++++++++++++
 tb/tb_dsp_adc_framer.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_adc_pkg.sv
// Shared definitions for the ADC frame assembler: FSM encoding, receiver word
// layout and counter helpers.
package dsp_adc_pkg;

    localparam int DATA_W_DEF = 12;

    // Receiver word flags sit directly above the sample field.
    localparam int SOF_OFS = 1;
    localparam int OF_OFS  = 0;

    localparam int CNT_W = 16;

    localparam int ST_W = 2;
    localparam logic [ST_W-1:0] ST_HUNT    = 2'd0;
    localparam logic [ST_W-1:0] ST_FILL    = 2'd1;
    localparam logic [ST_W-1:0] ST_DISCARD = 2'd2;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [1:0]       inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {{(CNT_W-1){1'b0}}, inc};
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/dsp_adc_frame_ram.sv
// Simple dual-port frame buffer: synchronous write, registered read.
// The read register doubles as the framer's output data register.
module dsp_adc_frame_ram #(
    parameter  int DEPTH = 128,
    parameter  int WIDTH = 12,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array itself is never reset so it maps onto block RAM; only the
    // read register, which is visible at the ports, gets a reset value.
    always_ff @(posedge i_clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/dsp_adc_framer.sv
// Rebuilds fixed-length interleaved frames from the ADC receiver stream; only clean
// frames are emitted. Define DSP_ADC_FRAMER_STATS_EN to enable o_frame_count.
module dsp_adc_framer
    import dsp_adc_pkg::*;
#(
    parameter  int DATA_W    = DATA_W_DEF,
    parameter  int NUM_CH    = 2,
    parameter  int FRAME_LEN = 64,
    parameter  int BUF_DEPTH = 128,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_valid,
    input  logic [DATA_W+1:0] i_data,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic [CH_W-1:0]   o_chan,
    output logic              o_last,
    output logic              o_drop,
    output logic [CNT_W-1:0]  o_drop_count,
    output logic [CNT_W-1:0]  o_frame_count
);

    localparam int AW  = $clog2(BUF_DEPTH);
    localparam int PW  = AW + 1;
    localparam int FCW = $clog2(FRAME_LEN + 1);
    localparam int IW  = $clog2(FRAME_LEN);

    localparam logic [PW-1:0]   DEPTH_P  = PW'(BUF_DEPTH);
    localparam logic [FCW-1:0]  LAST_CNT = FCW'(FRAME_LEN - 1);
    localparam logic [IW-1:0]   LAST_IDX = IW'(FRAME_LEN - 1);
    localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NUM_CH - 1);

    logic [ST_W-1:0] state, state_nxt;
    logic [PW-1:0]   wptr, wptr_nxt, cptr, cptr_nxt, rptr;
    logic [FCW-1:0]  cnt, cnt_nxt;
    logic [AW-1:0]   waddr;
    logic [1:0]      drops;
    logic            we, start, full, base_full, sof, ofl, rd_en;
    logic [CH_W-1:0] ch_idx;
    logic [IW-1:0]   rd_idx;

    assign sof       = i_data[DATA_W + SOF_OFS];
    assign ofl       = i_data[DATA_W + OF_OFS];
    assign full      = (wptr - rptr) == DEPTH_P;
    // Space check for a frame that would restart at the commit point.
    assign base_full = (cptr - rptr) == DEPTH_P;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        wptr_nxt  = wptr;
        cptr_nxt  = cptr;
        cnt_nxt   = cnt;
        waddr     = wptr[AW-1:0];
        we        = 1'b0;
        drops     = 2'd0;
        start     = 1'b0;
        if (i_valid) begin
            case (state)
                ST_FILL: begin
                    if (sof) begin
                        drops    = 2'd1;
                        wptr_nxt = cptr;
                        start    = 1'b1;
                    end else if (ofl || full) begin
                        drops     = 2'd1;
                        wptr_nxt  = cptr;
                        cnt_nxt   = '0;
                        state_nxt = ST_DISCARD;
                    end else begin
                        we       = 1'b1;
                        wptr_nxt = wptr + 1'b1;
                        if (cnt == LAST_CNT) begin
                            cptr_nxt  = wptr + 1'b1;
                            cnt_nxt   = '0;
                            state_nxt = ST_HUNT;
                        end else begin
                            cnt_nxt = cnt + 1'b1;
                        end
                    end
                end
                default: start = sof;
            endcase

            // A new frame always starts at the commit point, after any rewind.
            if (start) begin
                if (ofl || base_full) begin
                    drops     = drops + 2'd1;
                    wptr_nxt  = cptr;
                    cnt_nxt   = '0;
                    state_nxt = ST_DISCARD;
                end else begin
                    we        = 1'b1;
                    waddr     = cptr[AW-1:0];
                    wptr_nxt  = cptr + 1'b1;
                    cnt_nxt   = FCW'(1);
                    state_nxt = ST_FILL;
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state        <= ST_HUNT;
            wptr         <= '0;
            cptr         <= '0;
            cnt          <= '0;
            o_drop       <= 1'b0;
            o_drop_count <= '0;
        end else begin
            state        <= state_nxt;
            wptr         <= wptr_nxt;
            cptr         <= cptr_nxt;
            cnt          <= cnt_nxt;
            o_drop       <= (drops != 2'd0);
            o_drop_count <= sat_add(o_drop_count, drops);
        end
    end

    // Reader refills the output register whenever it is empty or being accepted.
    assign rd_en = (rptr != cptr) && (!o_valid || i_ready);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            rptr    <= '0;
            o_valid <= 1'b0;
            o_chan  <= '0;
            o_last  <= 1'b0;
            ch_idx  <= '0;
            rd_idx  <= '0;
        end else if (rd_en) begin
            rptr    <= rptr + 1'b1;
            o_valid <= 1'b1;
            o_chan  <= ch_idx;
            o_last  <= (rd_idx == LAST_IDX);
            if (rd_idx == LAST_IDX) begin
                rd_idx <= '0;
                ch_idx <= '0;
            end else begin
                rd_idx <= rd_idx + 1'b1;
                ch_idx <= (ch_idx == LAST_CH) ? '0 : ch_idx + 1'b1;
            end
        end else if (i_ready) begin
            o_valid <= 1'b0;
        end
    end

    dsp_adc_frame_ram #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (DATA_W)
    ) u_ram (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .we     (we),
        .waddr  (waddr),
        .wdata  (i_data[DATA_W-1:0]),
        .re     (rd_en),
        .raddr  (rptr[AW-1:0]),
        .rdata  (o_data)
    );

`ifdef DSP_ADC_FRAMER_STATS_EN
    logic commit;
    assign commit = (cptr_nxt != cptr);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_frame_count <= '0;
        end else if (commit) begin
            o_frame_count <= sat_add(o_frame_count, 2'd1);
        end
    end
`else
    assign o_frame_count = '0;
`endif

endmodule

// File: tb/tb_dsp_adc_framer.sv
// Self-checking bench for dsp_adc_framer: directed frames plus randomized frame
// stream, checked against a frame-level reference model and output scoreboard.
module tb_dsp_adc_framer;

    localparam int DATA_W    = 12;
    localparam int NUM_CH    = 2;
    localparam int FRAME_LEN = 8;
    localparam int BUF_DEPTH = 16;
    localparam int CH_W      = 1;

    logic              i_clk   = 1'b0;
    logic              i_rstn  = 1'b1;
    logic              i_valid = 1'b0;
    logic [DATA_W+1:0] i_data  = '0;
    logic              i_ready = 1'b0;
    logic              o_valid;
    logic [DATA_W-1:0] o_data;
    logic [CH_W-1:0]   o_chan;
    logic              o_last;
    logic              o_drop;
    logic [15:0]       o_drop_count;
    logic [15:0]       o_frame_count;

    dsp_adc_framer #(
        .DATA_W    (DATA_W),
        .NUM_CH    (NUM_CH),
        .FRAME_LEN (FRAME_LEN),
        .BUF_DEPTH (BUF_DEPTH)
    ) dut (
        .i_clk         (i_clk),
        .i_rstn        (i_rstn),
        .i_valid       (i_valid),
        .i_data        (i_data),
        .i_ready       (i_ready),
        .o_valid       (o_valid),
        .o_data        (o_data),
        .o_chan        (o_chan),
        .o_last        (o_last),
        .o_drop        (o_drop),
        .o_drop_count  (o_drop_count),
        .o_frame_count (o_frame_count)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic              last;
        logic [CH_W-1:0]   chan;
        logic [DATA_W-1:0] data;
    } beat_t;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model (frame level) ----------------
    beat_t             exp_q[$];
    logic [DATA_W-1:0] cur[$];
    bit                in_frame        = 1'b0;
    int                exp_drops       = 0;
    int                exp_drop_events = 0;
    int                exp_commits     = 0;

    function automatic void push_beat(input int k, input logic [DATA_W-1:0] d);
        beat_t b;
        b.last = (k == FRAME_LEN - 1);
        b.chan = CH_W'(k % NUM_CH);
        b.data = d;
        exp_q.push_back(b);
    endfunction

    function automatic void model_word(input bit sof, input bit ofl, input logic [DATA_W-1:0] s);
        int d = 0;
        if (sof) begin
            if (in_frame) d++;
            in_frame = 1'b0;
            cur.delete();
            if (ofl) d++;
            else begin
                in_frame = 1'b1;
                cur.push_back(s);
            end
        end else if (in_frame) begin
            if (ofl) begin
                d++;
                in_frame = 1'b0;
                cur.delete();
            end else begin
                cur.push_back(s);
                if (cur.size() == FRAME_LEN) begin
                    for (int k = 0; k < FRAME_LEN; k++) push_beat(k, cur[k]);
                    exp_commits++;
                    in_frame = 1'b0;
                    cur.delete();
                end
            end
        end
        exp_drops += d;
        if (d != 0) exp_drop_events++;
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        cur.delete();
        in_frame        = 1'b0;
        exp_drops       = 0;
        exp_drop_events = 0;
        exp_commits     = 0;
    endfunction

    // ---------------- ready driver ----------------
    int ready_mode = 0;  // 0 low, 1 high, 2 random
    always @(posedge i_clk) begin
        #1;
        case (ready_mode)
            0:       i_ready = 1'b0;
            1:       i_ready = 1'b1;
            default: i_ready = ($urandom_range(0, 99) < 65);
        endcase
    end

    // ---------------- output monitor / scoreboard ----------------
    int    n_xfer    = 0;
    int    n_pulse   = 0;
    bit    hold_pend = 1'b0;
    beat_t hold_val;

    always @(negedge i_clk) begin
        if (!i_rstn) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend)
                check("hold_stable", 32'({o_valid, o_last, o_chan, o_data}), 32'({1'b1, hold_val}));
            if (o_drop) n_pulse++;
            if (o_valid && i_ready) begin
                n_xfer++;
                if (exp_q.size() == 0) begin
                    check("beat_expected", 32'(exp_q.size()), 32'd1);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("beat", 32'({o_last, o_chan, o_data}), 32'(e));
                end
            end
            hold_pend = o_valid && !i_ready;
            hold_val  = {o_last, o_chan, o_data};
        end
    end

    // ---------------- stimulus helpers ----------------
    int gap_pct = 0;

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
            i_valid = 1'b0;
            i_data  = (DATA_W+2)'($urandom);
        end
    endtask

    task automatic send(input bit sof, input bit ofl, input logic [DATA_W-1:0] s, input bit feed);
        if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) idle($urandom_range(1, 2));
        @(posedge i_clk);
        #1;
        i_valid = 1'b1;
        i_data  = {sof, ofl, s};
        if (feed) model_word(sof, ofl, s);
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] base, input int of_pos, input bit feed);
        for (int k = 0; k < FRAME_LEN; k++)
            send(k == 0, k == of_pos, base + DATA_W'(k), feed);
    endtask

    task automatic drain();
        int budget;
        budget     = 400;
        ready_mode = 1;
        while (exp_q.size() != 0 && budget > 0) begin
            idle(1);
            budget--;
        end
        check("drain_done", 32'(exp_q.size()), 32'd0);
        idle(4);
        check("drain_idle_valid", 32'(o_valid), 32'd0);
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_drop_count"}, 32'(o_drop_count), 32'(exp_drops));
        check({tag, "_drop_pulses"}, 32'(n_pulse), 32'(exp_drop_events));
`ifdef DSP_ADC_FRAMER_STATS_EN
        check({tag, "_frame_count"}, 32'(o_frame_count), 32'(exp_commits));
`else
        check({tag, "_frame_count"}, 32'(o_frame_count), 32'd0);
`endif
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(o_valid), 32'd0);
        check({tag, "_data"}, 32'(o_data), 32'd0);
        check({tag, "_chan"}, 32'(o_chan), 32'd0);
        check({tag, "_last"}, 32'(o_last), 32'd0);
        check({tag, "_drop"}, 32'(o_drop), 32'd0);
        check({tag, "_drop_count"}, 32'(o_drop_count), 32'd0);
        check({tag, "_frame_count"}, 32'(o_frame_count), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int xfer0;
        // Reset
        #2 i_rstn = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (3) @(posedge i_clk);
        #1 i_rstn = 1'b1;
        ready_mode = 1;
        idle(3);

        // Clean frame, latency to first output
        for (int k = 0; k < FRAME_LEN; k++) send(k == 0, 1'b0, DATA_W'(k + 1), 1'b1);
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        check("lat_c1_valid", 32'(o_valid), 32'd0);
        @(posedge i_clk);
        #1;
        check("lat_c2_valid", 32'(o_valid), 32'd1);
        check("lat_c2_data", 32'(o_data), 32'h001);
        check("lat_c2_chan", 32'(o_chan), 32'd0);
        drain();
        check_counts("clean");

        // Overflow on sample 5, then a clean frame
        send_frame(12'h010, 4, 1'b1);
        send_frame(12'h020, -1, 1'b1);
        drain();
        check_counts("overflow");

        // Truncated frame restarted by a new SoF on sample 4
        for (int k = 0; k < 3; k++) send(k == 0, 1'b0, 12'h031 + DATA_W'(k), 1'b1);
        send_frame(12'h040, -1, 1'b1);
        drain();
        check_counts("truncate");

        // Buffer exhaustion with the sink stalled
        ready_mode = 0;
        idle(2);
        send_frame(12'h100, -1, 1'b0);
        send_frame(12'h200, -1, 1'b0);
        send_frame(12'h300, -1, 1'b0);
        send_frame(12'h400, -1, 1'b0);
        idle(4);
        check("full_valid_held", 32'(o_valid), 32'd1);
        check("full_data_held", 32'(o_data), 32'h100);
        for (int k = 0; k < FRAME_LEN; k++) push_beat(k, 12'h100 + DATA_W'(k));
        for (int k = 0; k < FRAME_LEN; k++) push_beat(k, 12'h200 + DATA_W'(k));
        exp_drops       += 2;
        exp_drop_events += 2;
        exp_commits     += 2;
        check_counts("full");
        xfer0 = n_xfer;
        drain();
        check("full_xfers", 32'(n_xfer - xfer0), 32'(2 * FRAME_LEN));

        // Async reset in the middle of a frame with an output held
        ready_mode = 0;
        idle(2);
        send_frame(12'h500, -1, 1'b1);
        send(1'b1, 1'b0, 12'h600, 1'b1);
        send(1'b0, 1'b0, 12'h601, 1'b1);
        send(1'b0, 1'b0, 12'h602, 1'b1);
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        check("pre_reset_valid", 32'(o_valid), 32'd1);
        #2 i_rstn = 1'b0;
        #1 check_reset_outputs("async_reset");
        model_reset();
        n_pulse = 0;
        repeat (2) @(posedge i_clk);
        #1 i_rstn = 1'b1;
        ready_mode = 1;
        for (int k = 0; k < 6; k++) send(1'b0, 1'b0, DATA_W'($urandom), 1'b1);
        idle(4);
        check("post_reset_quiet", 32'(o_valid), 32'd0);
        send_frame(12'h700, -1, 1'b1);
        drain();
        check_counts("post_reset");

        // Three clean frames and one overflowed frame
        send_frame(12'h800, -1, 1'b1);
        send_frame(12'h810, -1, 1'b1);
        send_frame(12'h820, -1, 1'b1);
        send_frame(12'h830, 3, 1'b1);
        drain();
        check_counts("stats");

        // Randomized frame stream with faults, gaps and back-pressure
        ready_mode = 2;
        gap_pct    = 20;
        for (int a = 0; a < 40; a++) begin
            int kind;
            int p;
            int budget;
            logic [DATA_W-1:0] base;
            budget = 300;
            while (exp_q.size() > BUF_DEPTH - FRAME_LEN && budget > 0) begin
                idle(1);
                budget--;
            end
            if (budget == 0) check("flow_wait", 32'(exp_q.size()), 32'(BUF_DEPTH - FRAME_LEN));
            if ($urandom_range(0, 9) < 3)
                repeat ($urandom_range(1, 3)) send(1'b0, 1'($urandom), DATA_W'($urandom), 1'b1);
            kind = $urandom_range(0, 4);
            base = DATA_W'($urandom);
            case (kind)
                2: send_frame(base, $urandom_range(0, FRAME_LEN - 1), 1'b1);
                3, 4: begin
                    p = $urandom_range(1, FRAME_LEN - 1);
                    for (int k = 0; k < p; k++) send(k == 0, 1'b0, base + DATA_W'(k), 1'b1);
                    if (kind == 3) send_frame(base ^ 12'hA5A, -1, 1'b1);
                    else           send(1'b1, 1'b1, base, 1'b1);
                end
                default: send_frame(base, -1, 1'b1);
            endcase
        end
        gap_pct = 0;
        drain();
        check_counts("random");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
